// File: rtl/ram_arb_pkg.sv
// Shared types and default sizing for the burst RAM arbiter.
// Imported by the arbiter top and its round-robin picker.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  localparam int unsigned DefWidth  = 32;
  localparam int unsigned DefDepth  = 256;
  localparam int unsigned DefNumReq = 2;
  localparam int unsigned DefLenW   = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr_i, wrapping.
// Ports: req_i, ptr_i in; one-hot gnt_o, binary idx_o, valid_o (any req) out.
module rr_arbiter #(
  parameter  int unsigned NumReq = 2,
  localparam int unsigned IdW    = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdW-1:0]    ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdW-1:0]    idx_o,
  output logic              valid_o
);

  logic [IdW:0] cand;
  logic         found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = {1'b0, ptr_i} + (IdW+1)'(i);
      if (cand >= (IdW+1)'(NumReq)) begin
        cand = cand - (IdW+1)'(NumReq);
      end
      if (!found && req_i[cand[IdW-1:0]]) begin
        found = 1'b1;
        gnt_o[cand[IdW-1:0]] = 1'b1;
        idx_o = cand[IdW-1:0];
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/ram_burst_arbiter.sv
// Shares a single-port 1-cycle-latency RAM among NumReq burst masters, one burst at a time.
// Ports: req/we/addr/len command per master, gnt pulse, write beats (wdata/wvalid/wready),
// broadcast rdata with one-hot rvalid and rlast, busy, and the RAM we/re/addr/wdata/rdata side.
module ram_burst_arbiter
  import ram_arb_pkg::*;
#(
  parameter  int unsigned Width  = DefWidth,
  parameter  int unsigned Depth  = DefDepth,
  parameter  int unsigned NumReq = DefNumReq,
  parameter  int unsigned LenW   = DefLenW,
  localparam int unsigned Aw     = $clog2(Depth),
  localparam int unsigned IdW    = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumReq-1:0]        req_i,
  input  logic [NumReq-1:0]        req_we_i,
  input  logic [NumReq*Aw-1:0]     req_addr_i,
  input  logic [NumReq*LenW-1:0]   req_len_i,
  output logic [NumReq-1:0]        gnt_o,
  input  logic [NumReq*Width-1:0]  wdata_i,
  input  logic [NumReq-1:0]        wvalid_i,
  output logic [NumReq-1:0]        wready_o,
  output logic [Width-1:0]         rdata_o,
  output logic [NumReq-1:0]        rvalid_o,
  output logic                     rlast_o,
  output logic                     busy_o,
  output logic                     ram_we_o,
  output logic                     ram_re_o,
  output logic [Aw-1:0]            ram_addr_o,
  output logic [Width-1:0]         ram_wdata_o,
  input  logic [Width-1:0]         ram_rdata_i
);

  logic [Aw-1:0]    addr_a  [NumReq];
  logic [LenW-1:0]  len_a   [NumReq];
  logic [Width-1:0] wdata_a [NumReq];

  for (genvar g = 0; g < NumReq; g++) begin : g_unpack
    assign addr_a[g]  = req_addr_i[g*Aw +: Aw];
    assign len_a[g]   = req_len_i[g*LenW +: LenW];
    assign wdata_a[g] = wdata_i[g*Width +: Width];
  end

  state_e            state_q, state_d;
  logic [IdW-1:0]    id_q, id_d;
  logic [Aw-1:0]     addr_q, addr_d;
  logic [LenW-1:0]   cnt_q, cnt_d;
  logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NumReq-1:0] rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;

  logic [NumReq-1:0] arb_gnt;
  logic [IdW-1:0]    arb_idx;
  logic              arb_valid;

  rr_arbiter #(
    .NumReq (NumReq)
  ) u_rr (
    .req_i   (req_i),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    rvalid_d    = '0;
    rlast_d     = 1'b0;
    gnt_o       = '0;
    wready_o    = '0;
    ram_we_o    = 1'b0;
    ram_re_o    = 1'b0;
    ram_addr_o  = addr_q;
    ram_wdata_o = wdata_a[id_q];
    unique case (state_q)
      IDLE: begin
        // Gate with reset so a held request cannot pulse gnt while in reset.
        if (arb_valid && rst_ni) begin
          gnt_o    = arb_gnt;
          id_d     = arb_idx;
          addr_d   = addr_a[arb_idx];
          cnt_d    = len_a[arb_idx];
          rr_ptr_d = (arb_idx == IdW'(NumReq-1))
                     ? '0 : arb_idx + IdW'(1);
          state_d  = req_we_i[arb_idx] ? WRITE : READ;
        end
      end
      WRITE: begin
        wready_o[id_q] = 1'b1;
        ram_we_o       = wvalid_i[id_q];
        if (wvalid_i[id_q]) begin
          addr_d = addr_q + Aw'(1);
          cnt_d  = cnt_q - LenW'(1);
          if (cnt_q == '0) begin
            state_d = IDLE;
          end
        end
      end
      READ: begin
        ram_re_o         = 1'b1;
        addr_d           = addr_q + Aw'(1);
        cnt_d            = cnt_q - LenW'(1);
        rvalid_d[id_q]   = 1'b1;
        rlast_d          = (cnt_q == '0);
        if (cnt_q == '0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      id_q     <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      rvalid_q <= '0;
      rlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rlast_o  = rlast_q;
  assign busy_o   = (state_q != IDLE);
  assign rdata_o  = ram_rdata_i;

endmodule
